gate_unit_arbiter: RTL

- Shares one 5-bit two-operand logic/arithmetic unit between two requesters.
- Each requester presents operands P, Q and an opcode over a valid/ready handshake.
- The arbiter grants round-robin, latches operands, evaluates the unit and returns a registered result tagged with the requester id.
- Sits between operand producers and the gate/arithmetic datapath; the datapath itself is the sub-module below.

---
 rtl/gate_arb_pkg.sv | 16 +
 rtl/gate_unit_arbiter_if.sv | 37 +++
 rtl/gate_op_unit.sv | 27 ++
 rtl/gate_unit_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// Shared opcode constants, FSM encoding and default widths for the gate unit arbiter.
package gate_arb_pkg;
    localparam int W   = 5;
    localparam int OPW = 2;

    localparam logic [OPW-1:0] OP_ADD = 2'b00;
    localparam logic [OPW-1:0] OP_AND = 2'b01;
    localparam logic [OPW-1:0] OP_OR  = 2'b10;
    localparam logic [OPW-1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;
endpackage

// File: rtl/gate_unit_arbiter_if.sv
// Two requester valid/ready channels plus one result channel; master = requesters/consumer, slave = arbiter.
interface gate_unit_arbiter_if #(
    parameter int W   = gate_arb_pkg::W,
    parameter int OPW = gate_arb_pkg::OPW
);
    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_p;
    logic [W-1:0]   req0_q;
    logic [OPW-1:0] req0_op;
    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_p;
    logic [W-1:0]   req1_q;
    logic [OPW-1:0] req1_op;
    logic           res_valid;
    logic           res_ready;
    logic           res_id;
    logic [W:0]     res_data;
    logic           res_zero;

    modport master (
        output req0_valid, req0_p, req0_q, req0_op,
        output req1_valid, req1_p, req1_q, req1_op,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_data, res_zero
    );

    modport slave (
        input  req0_valid, req0_p, req0_q, req0_op,
        input  req1_valid, req1_p, req1_q, req1_op,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_data, res_zero
    );
endinterface

// File: rtl/gate_op_unit.sv
// Combinational 2-operand ADD/AND/OR/XOR unit with W+1-bit result and zero flag.
// Zero latency; no handshake, the caller owns all flow control.
module gate_op_unit
    import gate_arb_pkg::*;
#(
    parameter int W   = gate_arb_pkg::W,
    parameter int OPW = gate_arb_pkg::OPW
) (
    input  logic [W-1:0]   p,
    input  logic [W-1:0]   q,
    input  logic [OPW-1:0] op,
    output logic [W:0]     result,
    output logic           zero
);
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {1'b0, p} + {1'b0, q};
            OP_AND:  result = {1'b0, p & q};
            OP_OR:   result = {1'b0, p | q};
            OP_XOR:  result = {1'b0, p ^ q};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin share of one gate_op_unit between two requesters; result valid two edges after accept.
// Result holds in HOLD until res_ready; requester readies stay low until the result is taken.
module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter int W   = gate_arb_pkg::W,
    parameter int OPW = gate_arb_pkg::OPW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_unit_arbiter_if.slave   bus
);
    state_e         state;
    logic           last_grant;
    logic [W-1:0]   p_r;
    logic [W-1:0]   q_r;
    logic [OPW-1:0] op_r;
    logic           id_r;

    logic           res_valid_r;
    logic           res_id_r;
    logic [W:0]     res_data_r;
    logic           res_zero_r;

    logic           grant_id;
    logic           any_valid;
    logic           idle_ok;
    logic [W:0]     unit_result;
    logic           unit_zero;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign any_valid      = bus.req0_valid | bus.req1_valid;
    assign idle_ok        = rst_n && (state == ST_IDLE);
    assign bus.req0_ready = idle_ok && bus.req0_valid && !grant_id;
    assign bus.req1_ready = idle_ok && bus.req1_valid && grant_id;

    gate_op_unit #(.W(W), .OPW(OPW)) u_op (
        .p      (p_r),
        .q      (q_r),
        .op     (op_r),
        .result (unit_result),
        .zero   (unit_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            p_r         <= '0;
            q_r         <= '0;
            op_r        <= '0;
            id_r        <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            res_data_r  <= '0;
            res_zero_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        p_r        <= grant_id ? bus.req1_p  : bus.req0_p;
                        q_r        <= grant_id ? bus.req1_q  : bus.req0_q;
                        op_r       <= grant_id ? bus.req1_op : bus.req0_op;
                        id_r       <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data_r  <= unit_result;
                    res_zero_r  <= unit_zero;
                    res_id_r    <= id_r;
                    res_valid_r <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_zero  = res_zero_r;
endmodule
